bcd_display: RTL and testbench
==============================

# bcd_display

Display back end for the calculator datapath. It takes the 27-bit binary result and the OutOfRange flag produced by the arithmetic unit. It converts the result to eight BCD digits using a sequential shift-add-3 (double-dabble) engine, then drives a time-multiplexed, common-anode, eight-digit seven-segment display. The conversion is on-change: a new conversion starts only when the input differs from the last converted value.

## Interface
- SCAN_DIV, default 100000: clocks each digit stays lit (≥2). Bench uses 4.
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  synchronous, active-low reset
- in_data  input  27  binary value to display; valid range 0..99,999,999
- OutOfRange  input  1  error flag from the arithmetic unit
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered
- an  output  8  digit enables, active-low one-hot, registered; bit 0 is the rightmost digit
- busy  output  1  high while a conversion is in progress (CONV or DONE)

## Operation
- Registers:
  - last[26:0]: last value accepted for conversion.
  - sh[26:0]: binary shift register.
  - bcd[31:0]: working BCD register.
  - cnt[4:0]: iteration counter.
  - disp[31:0]: committed digits.
  - ovf: committed over-range flag.
  - digit index idx[2:0].
  - scan counter, 0..SCAN_DIV-1.
- FSM states: IDLE, CONV, DONE.
- IDLE, when in_data != last:
  - last ← in_data, sh ← in_data, bcd ← 0, cnt ← 0.
  - Go to CONV.
- IDLE, otherwise: stay in IDLE.
- CONV, each cycle:
  - Every nibble of bcd ≥5 gets +3.
  - Then {bcd,sh} is shifted left by 1 (shift-in 0), cnt++.
  - After the 27th shift (cnt reaches 27), go to DONE.
- DONE:
  - disp ← bcd[31:0] and ovf ← (last > 99,999,999).
  - Go to IDLE.
- Input changes during CONV/DONE are ignored. The change is detected in the next IDLE cycle, since in_data != last still holds.
- Digit value shown on digit i:
  - If ovf: dash, seg = 0xBF (only g lit).
  - Else if disp nibble i and all higher nibbles are zero, and i ≠ 0: blank, 0xFF (leading-zero blanking).
  - Else: the decimal glyph.
- Glyphs, active-low with dp off: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
- Value 0 shows a single "0" on digit 0.
- Decimal point: seg[7] is driven low on digit 7 when the live OutOfRange input is 1. It applies on top of any glyph, blank or dash. It is not latched.
- Scan:
  - The scan counter increments every cycle.
  - When it wraps from SCAN_DIV-1 to 0, idx increments, 7 wraps to 0.
  - Registered outputs: an ← ~(1<<idx), seg ← glyph(idx).

## Timing
- Reset values: state IDLE, last=0, disp=0, ovf=0, idx=0, scan counter 0, busy=0, an=0xFF, seg=0xFF.
  - First cycle after release: an=0xFE, seg=0xC0.
- Conversion latency:
  - in_data changes before edge N; it is latched at edge N.
  - The 27 CONV edges are N+1..N+27; DONE commits disp at edge N+28.
  - seg reflects the new value from edge N+29 for the digit then selected.
- busy is 1 from the cycle after edge N through the cycle disp commits (28 cycles), then 0.
- Back-to-back changes: a change arriving at any point during busy starts a new conversion on the first IDLE cycle. Only the final stable value is guaranteed to be displayed.
- Digit dwell: exactly SCAN_DIV cycles per digit; the full refresh period is 8×SCAN_DIV.
- Reset asserted mid-conversion aborts it. Conversion state and disp return to reset values; no partial result is committed.
- An in_data change in the same cycle as reset release is latched on the following edge.

## Test plan
- Reset, then release with in_data=0 → an=FF/seg=FF during reset. Then an cycles FE,FD,…,7F every 4 clocks; digit 0 shows C0 and digits 1–7 show FF. busy never rises.
- in_data=12345678 → busy high for 28 cycles. Afterwards digit0=80, digit1=F8, digit2=82, digit3=92, digit4=99, digit5=B0, digit6=A4, digit7=F9.
- in_data=99999999 → all eight digits 0x90. Then in_data=100000000 → all eight digits 0xBF.
- in_data=405, OutOfRange=1 → digit0=92, digit1=C0, digit2=99, digits3–6=FF, digit7=7F. Dropping OutOfRange to 0 makes digit7=FF with no reconversion.
- Change in_data 5→77 ten cycles into a conversion of 5 → 5 is committed at latency 28. 77 then converts immediately: busy stays low for exactly one IDLE cycle, and digits show 77.
- Reset pulsed mid-conversion of 12345678 → display returns to "0" and last=0. After release, 12345678 is reconverted and shown correctly.

Source files
------------

// File: rtl/bcd_display.sv
// Calculator display back end: sequential double-dabble binary-to-BCD conversion
// feeding a multiplexed, common-anode, eight-digit seven-segment display.
module bcd_display #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [26:0] in_data,
    input  logic        OutOfRange,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [26:0] MaxValue = 27'd99_999_999;
    localparam logic [4:0] LastIter = 5'd26;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [26:0]      last_q, last_d;
    logic [26:0]      sh_q, sh_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [31:0]      bcd_adj;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       idx_q, idx_d;
    logic [ScanW-1:0] scan_q, scan_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       an_q, an_d;

    logic [7:0]       blank;
    logic             any_nz;
    logic [3:0]       digit;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        unique case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            last_q  <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            scan_q  <= '0;
            seg_q   <= 8'hFF;
            an_q    <= 8'hFF;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Add-3 correction on every BCD nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_data != last_q) begin
                    last_d  = in_data;
                    sh_d    = in_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d = {bcd_adj[30:0], sh_q[26]};
                sh_d  = {sh_q[25:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                disp_d  = bcd_q;
                ovf_d   = (last_q > MaxValue);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scan_d = scan_q + ScanW'(1);
        idx_d  = idx_q;
        if (scan_q == ScanLast) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    // blank[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        any_nz = 1'b0;
        blank  = '0;
        for (int i = 7; i >= 0; i--) begin
            any_nz   = any_nz | (disp_q[4*i +: 4] != 4'd0);
            blank[i] = ~any_nz;
        end
    end

    always_comb begin
        digit = disp_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(8'd1 << idx_q);
        if (ovf_q) begin
            seg_d = 8'hBF;
        end else if (blank[idx_q] && (idx_q != 3'd0)) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = glyph(digit);
        end
        // Live error flag lights the leftmost decimal point over whatever is shown.
        if ((idx_q == 3'd7) && OutOfRange) begin
            seg_d[7] = 1'b0;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_display.sv
// Directed bench for bcd_display: expected busy lengths and per-digit segment codes
// are queued when stimulus is driven and checked as the scan presents each digit.
module tb_bcd_display;

    logic        clk;
    logic        rstn;
    logic [26:0] in_data;
    logic        OutOfRange;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        busy;

    bcd_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .OutOfRange (OutOfRange),
        .seg        (seg),
        .an         (an),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int busy_hits = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always @(posedge clk) if (busy === 1'b1) busy_hits++;

    task automatic push_exp(input logic [31:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // Independent decimal model of the displayed glyph.
    function automatic logic [7:0] model_seg(input int unsigned v, input int i, input logic oor);
        logic [7:0]  g;
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        d = (v / p) % 10;
        if (v > 99999999) g = 8'hBF;
        else if ((i != 0) && ((v / p) == 0)) g = 8'hFF;
        else begin
            case (d)
                0: g = 8'hC0;
                1: g = 8'hF9;
                2: g = 8'hA4;
                3: g = 8'hB0;
                4: g = 8'h99;
                5: g = 8'h92;
                6: g = 8'h82;
                7: g = 8'hF8;
                8: g = 8'h80;
                default: g = 8'h90;
            endcase
        end
        if ((i == 7) && oor) g[7] = 1'b0;
        return g;
    endfunction

    task automatic push_value(input int unsigned v, input logic oor);
        for (int i = 0; i < 8; i++) push_exp({24'd0, model_seg(v, i, oor)}, $sformatf("v%0d_digit%0d", v, i));
    endtask

    task automatic measure_busy(input int start);
        int n;
        n = start;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) break;
        end
        compare(32'(n));
    endtask

    task automatic sweep();
        logic [7:0] want;
        logic       found;
        string      t;
        for (int d = 0; d < 8; d++) begin
            want  = ~(8'd1 << d);
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                if (an === want) found = 1'b1;
                else @(negedge clk);
            end
            if (found) compare({24'd0, seg});
            else begin
                void'(exp_q.pop_front());
                t = tag_q.pop_front();
                n_checks++;
                n_err++;
                $error("FAIL %s observed=an_%h expected=an_%h (timeout)", t, an, want);
            end
        end
    endtask

    task automatic drive(input int unsigned v, input logic oor);
        @(negedge clk);
        in_data    = 27'(v);
        OutOfRange = oor;
        push_exp(32'd28, $sformatf("busy_len_v%0d", v));
        push_value(v, oor);
        measure_busy(0);
        @(negedge clk);
        sweep();
    endtask

    initial begin
        int snap;
        int r1, gap, r2, ph, dwell;
        rstn       = 1'b0;
        in_data    = '0;
        OutOfRange = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(32'hFF, "reset_an");
        push_exp(32'hFF, "reset_seg");
        push_exp(32'h0, "reset_busy");
        compare({24'd0, an});
        compare({24'd0, seg});
        compare({31'd0, busy});

        // Release with zero input: single "0" on digit 0, busy idle.
        rstn = 1'b1;
        snap = busy_hits;
        @(negedge clk);
        push_exp(32'hFE, "first_an");
        push_exp(32'hC0, "first_seg");
        compare({24'd0, an});
        compare({24'd0, seg});
        dwell = 0;
        for (int i = 0; i < 20 && an === 8'hFE; i++) begin
            dwell++;
            @(negedge clk);
        end
        push_exp(32'd4, "dwell_digit0");
        compare(32'(dwell));
        push_value(0, 1'b0);
        sweep();
        push_exp(32'd0, "busy_after_reset_zero");
        compare(32'(busy_hits - snap));

        drive(12345678, 1'b0);
        drive(99999999, 1'b0);
        drive(100000000, 1'b0);
        drive(405, 1'b1);

        // Dropping the error flag changes only the decimal point, no reconversion.
        snap = busy_hits;
        OutOfRange = 1'b0;
        @(negedge clk);
        push_value(405, 1'b0);
        sweep();
        push_exp(32'd0, "no_reconv_on_oor");
        compare(32'(busy_hits - snap));

        // Change input mid-conversion: 5 completes, then 77 after one idle cycle.
        @(negedge clk);
        in_data = 27'd5;
        push_exp(32'd28, "b2b_run1");
        push_exp(32'd1, "b2b_gap");
        push_exp(32'd28, "b2b_run2");
        r1 = 0; gap = 0; r2 = 0; ph = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            case (ph)
                0: if (busy) r1++; else begin gap = 1; ph = 1; end
                1: if (!busy) gap++; else begin r2 = 1; ph = 2; end
                2: if (busy) r2++; else ph = 3;
                default: ;
            endcase
            if (i == 9) in_data = 27'd77;
        end
        compare(32'(r1));
        compare(32'(gap));
        compare(32'(r2));
        push_value(77, 1'b0);
        sweep();

        // Reset mid-conversion aborts it; the same input reconverts after release.
        @(negedge clk);
        in_data = 27'd12345678;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        push_exp(32'hFF, "midreset_an");
        push_exp(32'hFF, "midreset_seg");
        push_exp(32'h0, "midreset_busy");
        compare({24'd0, an});
        compare({24'd0, seg});
        compare({31'd0, busy});
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        push_exp(32'hFE, "postreset_an");
        push_exp(32'hC0, "postreset_seg");
        push_exp(32'h1, "postreset_busy");
        compare({24'd0, an});
        compare({24'd0, seg});
        compare({31'd0, busy});
        push_exp(32'd28, "postreset_busy_len");
        push_value(12345678, 1'b0);
        measure_busy(1);
        @(negedge clk);
        sweep();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
